// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, port indices and arbiter FSM states.
package noc_pkg;

  localparam logic [2:0] FLIT_HDR  = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_N = 1;
  localparam int unsigned PORT_E = 2;
  localparam int unsigned PORT_W = 3;
  localparam int unsigned PORT_S = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Only the exact header/tail codes are special; every other code is a body flit.
  function automatic logic is_hdr(input logic [2:0] id);
    return id == FLIT_HDR;
  endfunction

  function automatic logic is_tail(input logic [2:0] id);
    return id == FLIT_TAIL;
  endfunction

endpackage

// File: rtl/pkt_rr_arbiter_if.sv
// Requester/arbiter bundle: per-port requests and flit types in, grant and flow status out.
interface pkt_rr_arbiter_if #(
  parameter int unsigned NPORTS  = 5,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned TOW     = 12
);
  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic [NPORTS-1:0]   req;
  logic [3*NPORTS-1:0] flit_id;
  logic                credit_ret;
  logic [TOW-1:0]      timeout_limit;
  logic [NPORTS-1:0]   grant;
  logic                xfer;
  logic [CW-1:0]       credit_cnt;
  logic                timeout_err;

  modport master (
    output req, flit_id, credit_ret, timeout_limit,
    input  grant, xfer, credit_cnt, timeout_err
  );

  modport slave (
    input  req, flit_id, credit_ret, timeout_limit,
    output grant, xfer, credit_cnt, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward from i_ptr+1, wrapping.
module rr_pick #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]                  i_req,
  input  logic [((N>1)?$clog2(N):1)-1:0] i_ptr,
  output logic [N-1:0]                  o_gnt,
  output logic [((N>1)?$clog2(N):1)-1:0] o_idx,
  output logic                          o_any
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  int unsigned w_idx;

  // Scan N positions after the pointer; the last-served port is visited last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_idx = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(i_ptr) + k) % N;
      if (!o_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_idx        = PW'(w_idx);
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin output arbiter with credit flow control and stall timeout.
module pkt_rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NPORTS  = 5,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned TOW     = 12
) (
  input  logic             clk,
  input  logic             rst,
  pkt_rr_arbiter_if.slave  io_bus
);
  localparam int unsigned    PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned    CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
  localparam logic [PW-1:0]  PTR_RST  = PW'(NPORTS - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [NPORTS-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]     r_owner, w_owner_nxt;
  logic [PW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [TOW-1:0]    r_stall, w_stall_nxt;
  logic [CW-1:0]     r_credit;

  logic [NPORTS-1:0] w_hdr_req;
  logic [NPORTS-1:0] w_pick_gnt;
  logic [PW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic [2:0]        w_owner_flit;
  logic              w_xfer;
  logic              w_tail_xfer;
  logic              w_timeout;

  // Only ports presenting a header flit may compete for a new packet grant.
  always_comb begin
    w_hdr_req = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      w_hdr_req[i] = io_bus.req[i] & is_hdr(io_bus.flit_id[3*i +: 3]);
    end
  end

  rr_pick #(.N(NPORTS)) u_pick (
    .i_req (w_hdr_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_owner_flit = io_bus.flit_id[3*r_owner +: 3];
  assign w_xfer       = (r_state == ST_BUSY) & io_bus.req[r_owner] & (r_credit != '0);
  assign w_tail_xfer  = w_xfer & is_tail(w_owner_flit);
  assign w_timeout    = (r_state == ST_BUSY) & (io_bus.timeout_limit != '0) &
                        (r_stall == io_bus.timeout_limit);

  // A tail moving in the timeout cycle is a normal completion, so it masks the error pulse.
  assign io_bus.grant       = r_grant;
  assign io_bus.xfer        = w_xfer;
  assign io_bus.credit_cnt  = r_credit;
  assign io_bus.timeout_err = w_timeout & ~w_tail_xfer;

  // Next-state logic: grant on a header in IDLE, release on tail transfer or stall timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_stall_nxt  = r_stall;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt  = ST_BUSY;
          w_grant_nxt  = w_pick_gnt;
          w_owner_nxt  = w_pick_idx;
          w_rr_ptr_nxt = w_pick_idx;
          w_stall_nxt  = '0;
        end
      end
      ST_BUSY: begin
        if (w_tail_xfer || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
        if (w_xfer) begin
          w_stall_nxt = '0;
        end else if (r_stall != '1) begin
          w_stall_nxt = r_stall + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // FSM, grant, owner, pointer and stall registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= PTR_RST;
      r_stall  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_stall  <= w_stall_nxt;
    end
  end

  // Downstream credit counter: spend on xfer, refill on credit_ret, clamp at CREDITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= CRED_MAX;
    end else begin
      case ({w_xfer, io_bus.credit_ret})
        2'b10:   r_credit <= r_credit - 1'b1;
        2'b01:   if (r_credit != CRED_MAX) r_credit <= r_credit + 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Self-checking bench for pkt_rr_arbiter: directed scenarios plus randomized traffic vs. a packet-level model.
module tb_pkt_rr_arbiter;
  import noc_pkg::*;

  localparam int unsigned NP = 5;
  localparam int unsigned CR = 4;
  localparam int unsigned TW = 12;
  localparam int unsigned CW = $clog2(CR + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_rr_arbiter_if #(.NPORTS(NP), .CREDITS(CR), .TOW(TW)) bus ();

  pkt_rr_arbiter #(.NPORTS(NP), .CREDITS(CR), .TOW(TW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner is -1 when the output is free.
  int m_owner = -1, m_ptr = NP - 1, m_cred = CR, m_stall = 0;
  bit m_xfer, m_terr, m_tail;
  int nx_owner, nx_ptr, nx_cred, nx_stall;

  // Sources: each port sends ptot flits as packets of plen flits.
  int plen[NP], ptot[NP], ppos[NP];
  bit pen[NP];
  int pgap = 0;
  bit rnd_body = 0;

  function automatic logic [2:0] body_code();
    if (!rnd_body) return FLIT_BODY;
    case ($urandom_range(0, 5))
      0:       return 3'b010;
      1:       return 3'b000;
      2:       return 3'b011;
      3:       return 3'b101;
      4:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic void clear_ports();
    for (int i = 0; i < NP; i++) begin
      pen[i] = 0; plen[i] = 2; ptot[i] = 0; ppos[i] = 0;
    end
    pgap = 0;
    rnd_body = 0;
  endfunction

  function automatic void abandon(input int i);
    if (plen[i] > 0) ppos[i] = ((ppos[i] + plen[i] - 1) / plen[i]) * plen[i];
  endfunction

  task automatic apply_ports();
    logic [NP-1:0]   r;
    logic [3*NP-1:0] f;
    r = '0;
    f = '0;
    for (int i = 0; i < NP; i++) begin
      if (pen[i] && ppos[i] < ptot[i] && $urandom_range(0, 99) >= pgap) begin
        r[i] = 1'b1;
        if (ppos[i] % plen[i] == 0)                f[3*i +: 3] = FLIT_HDR;
        else if (ppos[i] % plen[i] == plen[i] - 1) f[3*i +: 3] = FLIT_TAIL;
        else                                       f[3*i +: 3] = body_code();
      end else begin
        f[3*i +: 3] = 3'($urandom_range(0, 7));
      end
    end
    bus.req     = r;
    bus.flit_id = f;
  endtask

  function automatic logic [2:0] flit_of(input int p);
    logic [3*NP-1:0] fv;
    fv = bus.flit_id >> (3 * p);
    return fv[2:0];
  endfunction

  function automatic logic [NP-1:0] exp_grant();
    if (m_owner < 0) return '0;
    return NP'(1) << m_owner;
  endfunction

  // Expected outputs for the present inputs and the state after the next edge.
  function automatic void model_eval();
    bit to;
    int sum, p;
    m_xfer = 0; m_tail = 0; to = 0;
    if (m_owner >= 0) begin
      m_xfer = (bus.req[m_owner] === 1'b1) && (m_cred > 0);
      m_tail = m_xfer && (flit_of(m_owner) === FLIT_TAIL);
      to = (bus.timeout_limit != 0) && (m_stall == int'(bus.timeout_limit));
    end
    m_terr = to && !m_tail;
    nx_owner = m_owner; nx_ptr = m_ptr; nx_stall = m_stall;
    sum = m_cred - (m_xfer ? 1 : 0) + (bus.credit_ret ? 1 : 0);
    nx_cred = (sum > int'(CR)) ? int'(CR) : sum;
    if (m_owner < 0) begin
      for (int k = 1; k <= NP; k++) begin
        p = (m_ptr + k) % NP;
        if (nx_owner < 0 && bus.req[p] === 1'b1 && flit_of(p) === FLIT_HDR) begin
          nx_owner = p; nx_ptr = p; nx_stall = 0;
        end
      end
    end else if (m_tail || to) begin
      nx_owner = -1;
    end else begin
      nx_stall = m_xfer ? 0 : ((m_stall >= (1 << TW) - 1) ? m_stall : m_stall + 1);
    end
    if (rst) begin
      nx_owner = -1; nx_ptr = NP - 1; nx_cred = CR; nx_stall = 0;
    end
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NP; i++) abandon(i);
    end else begin
      if (m_xfer) ppos[m_owner]++;
      if (m_terr) abandon(m_owner);
    end
    m_owner = nx_owner; m_ptr = nx_ptr; m_cred = nx_cred; m_stall = nx_stall;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_ports();
    settle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_ports();
    bus.credit_ret = 1'b1;
    bus.timeout_limit = '0;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      apply_ports(); settle(); step();
    end
    rst = 1'b0;
    bus.credit_ret = 1'b0;
    apply_ports(); settle();
    n_cmp++; if (bus.grant !== '0) begin n_err++; $display("FAIL reset_grant got=%b want=%b", bus.grant, 5'b0); end
    n_cmp++; if (bus.credit_cnt !== CW'(CR)) begin n_err++; $display("FAIL reset_credit got=%0d want=%0d", bus.credit_cnt, CR); end
    n_cmp++; if (bus.xfer !== 1'b0) begin n_err++; $display("FAIL reset_xfer got=%b want=0", bus.xfer); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr got=%b want=0", bus.timeout_err); end
    step();
  endtask

  task automatic test_single_packet();
    int xfers = 0;
    clear_ports();
    do_reset();
    bus.credit_ret = 1'b1;
    pen[PORT_L] = 1; plen[PORT_L] = 5; ptot[PORT_L] = 5;
    for (int c = 0; c < 10; c++) begin
      apply_ports(); settle();
      n_cmp++;
      if (bus.grant !== exp_grant() || bus.xfer !== m_xfer || bus.credit_cnt !== CW'(m_cred) || bus.timeout_err !== m_terr) begin
        n_err++;
        $display("FAIL single_cyc c=%0d grant=%b/%b xfer=%b/%b cred=%0d/%0d terr=%b/%b", c, bus.grant, exp_grant(), bus.xfer, m_xfer, bus.credit_cnt, m_cred, bus.timeout_err, m_terr);
      end
      if (c == 1) begin
        n_cmp++; if (bus.grant !== 5'b00001) begin n_err++; $display("FAIL single_grant got=%b want=00001", bus.grant); end
      end
      if (c == 6) begin
        n_cmp++; if (bus.grant !== 5'b00000) begin n_err++; $display("FAIL single_release got=%b want=00000", bus.grant); end
      end
      if (bus.xfer === 1'b1) xfers++;
      step();
    end
    n_cmp++; if (xfers != 5) begin n_err++; $display("FAIL single_xfers got=%0d want=5", xfers); end
  endtask

  task automatic test_rr_order();
    int order[$];
    int starts[$];
    int idx;
    logic [NP-1:0] prev = '0;
    clear_ports();
    do_reset();
    bus.credit_ret = 1'b1;
    for (int i = 0; i < NP; i++) begin
      pen[i] = 1; plen[i] = 2; ptot[i] = 4;
    end
    for (int c = 0; c < 40; c++) begin
      apply_ports(); settle();
      n_cmp++;
      if (bus.grant !== exp_grant() || bus.xfer !== m_xfer || bus.credit_cnt !== CW'(m_cred) || bus.timeout_err !== m_terr) begin
        n_err++;
        $display("FAIL rr_cyc c=%0d grant=%b/%b xfer=%b/%b cred=%0d/%0d terr=%b/%b", c, bus.grant, exp_grant(), bus.xfer, m_xfer, bus.credit_cnt, m_cred, bus.timeout_err, m_terr);
      end
      if (bus.grant !== '0 && prev === '0) begin
        idx = -1;
        for (int j = 0; j < NP; j++) if (bus.grant[j] === 1'b1) idx = j;
        order.push_back(idx);
        starts.push_back(c);
      end
      prev = bus.grant;
      step();
    end
    n_cmp++; if (order.size() != 10) begin n_err++; $display("FAIL rr_count got=%0d want=10", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      n_cmp++; if (order[k] != k % NP) begin n_err++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, order[k], k % NP); end
    end
    for (int k = 1; k < starts.size(); k++) begin
      n_cmp++; if (starts[k] - starts[k-1] != 3) begin n_err++; $display("FAIL rr_gap k=%0d got=%0d want=3", k, starts[k] - starts[k-1]); end
    end
  endtask

  task automatic test_credit_starve();
    int xfers = 0;
    clear_ports();
    do_reset();
    bus.credit_ret = 1'b0;
    pen[PORT_E] = 1; plen[PORT_E] = 6; ptot[PORT_E] = 6;
    for (int c = 0; c < 20; c++) begin
      if (c == 13) bus.credit_ret = 1'b1;
      if (c == 14) begin
        bus.credit_ret = 1'b0;
        n_cmp++; if (xfers != 4) begin n_err++; $display("FAIL starve_xfers got=%0d want=4", xfers); end
        xfers = 0;
      end
      apply_ports(); settle();
      n_cmp++;
      if (bus.grant !== exp_grant() || bus.xfer !== m_xfer || bus.credit_cnt !== CW'(m_cred) || bus.timeout_err !== m_terr) begin
        n_err++;
        $display("FAIL starve_cyc c=%0d grant=%b/%b xfer=%b/%b cred=%0d/%0d terr=%b/%b", c, bus.grant, exp_grant(), bus.xfer, m_xfer, bus.credit_cnt, m_cred, bus.timeout_err, m_terr);
      end
      if (c == 12) begin
        n_cmp++; if (bus.credit_cnt !== '0) begin n_err++; $display("FAIL starve_credit got=%0d want=0", bus.credit_cnt); end
        n_cmp++; if (bus.xfer !== 1'b0) begin n_err++; $display("FAIL starve_xfer_low got=%b want=0", bus.xfer); end
      end
      if (bus.xfer === 1'b1) xfers++;
      step();
    end
    n_cmp++; if (xfers != 1) begin n_err++; $display("FAIL starve_one_credit got=%0d want=1", xfers); end
    bus.credit_ret = 1'b1;
    for (int c = 0; c < 6; c++) begin
      apply_ports(); settle(); step();
    end
    apply_ports(); settle();
    n_cmp++; if (bus.grant !== '0) begin n_err++; $display("FAIL starve_drain got=%b want=00000", bus.grant); end
    step();
  endtask

  task automatic test_timeout();
    int terr_cnt = 0;
    int terr_cyc = -1;
    clear_ports();
    do_reset();
    bus.credit_ret = 1'b1;
    bus.timeout_limit = TW'(5);
    pen[PORT_N] = 1; plen[PORT_N] = 3; ptot[PORT_N] = 3;
    pen[PORT_S] = 1; plen[PORT_S] = 2; ptot[PORT_S] = 2;
    for (int c = 0; c < 15; c++) begin
      if (c == 2) pen[PORT_N] = 0;
      apply_ports(); settle();
      n_cmp++;
      if (bus.grant !== exp_grant() || bus.xfer !== m_xfer || bus.credit_cnt !== CW'(m_cred) || bus.timeout_err !== m_terr) begin
        n_err++;
        $display("FAIL tmo_cyc c=%0d grant=%b/%b xfer=%b/%b cred=%0d/%0d terr=%b/%b", c, bus.grant, exp_grant(), bus.xfer, m_xfer, bus.credit_cnt, m_cred, bus.timeout_err, m_terr);
      end
      if (bus.timeout_err === 1'b1) begin terr_cnt++; terr_cyc = c; end
      if (c == 1) begin
        n_cmp++; if (bus.grant !== 5'b00010) begin n_err++; $display("FAIL tmo_grant_n got=%b want=00010", bus.grant); end
      end
      if (c == 8) begin
        n_cmp++; if (bus.grant !== 5'b00000) begin n_err++; $display("FAIL tmo_release got=%b want=00000", bus.grant); end
      end
      if (c == 9) begin
        n_cmp++; if (bus.grant !== 5'b10000) begin n_err++; $display("FAIL tmo_next_s got=%b want=10000", bus.grant); end
      end
      step();
    end
    n_cmp++; if (terr_cnt != 1 || terr_cyc != 7) begin n_err++; $display("FAIL tmo_pulse count=%0d cyc=%0d want count=1 cyc=7", terr_cnt, terr_cyc); end
    bus.timeout_limit = '0;
  endtask

  task automatic test_credit_edges();
    clear_ports();
    do_reset();
    bus.credit_ret = 1'b0;
    bus.timeout_limit = '0;
    pen[PORT_L] = 1; plen[PORT_L] = 8; ptot[PORT_L] = 8;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) bus.credit_ret = 1'b1;
      if (c == 4) pen[PORT_L] = 0;
      if (c == 8) begin pen[PORT_L] = 1; bus.credit_ret = 1'b0; end
      if (c == 10) begin rst = 1'b1; bus.credit_ret = 1'b1; end
      if (c == 11) begin rst = 1'b0; bus.credit_ret = 1'b0; end
      apply_ports(); settle();
      n_cmp++;
      if (bus.grant !== exp_grant() || bus.xfer !== m_xfer || bus.credit_cnt !== CW'(m_cred) || bus.timeout_err !== m_terr) begin
        n_err++;
        $display("FAIL edge_cyc c=%0d grant=%b/%b xfer=%b/%b cred=%0d/%0d terr=%b/%b", c, bus.grant, exp_grant(), bus.xfer, m_xfer, bus.credit_cnt, m_cred, bus.timeout_err, m_terr);
      end
      if (c == 3) begin
        n_cmp++; if (bus.credit_cnt !== CW'(2) || bus.xfer !== 1'b1) begin n_err++; $display("FAIL edge_setup cred=%0d xfer=%b want cred=2 xfer=1", bus.credit_cnt, bus.xfer); end
      end
      if (c == 4) begin
        n_cmp++; if (bus.credit_cnt !== CW'(2)) begin n_err++; $display("FAIL edge_both got=%0d want=2", bus.credit_cnt); end
      end
      if (c == 7) begin
        n_cmp++; if (bus.credit_cnt !== CW'(CR)) begin n_err++; $display("FAIL edge_clamp got=%0d want=%0d", bus.credit_cnt, CR); end
      end
      if (c == 10) begin
        n_cmp++; if (bus.grant !== 5'b00001 || bus.credit_cnt !== CW'(2)) begin n_err++; $display("FAIL edge_pre_rst grant=%b cred=%0d want grant=00001 cred=2", bus.grant, bus.credit_cnt); end
      end
      if (c == 11) begin
        n_cmp++; if (bus.grant !== '0) begin n_err++; $display("FAIL edge_rst_grant got=%b want=00000", bus.grant); end
        n_cmp++; if (bus.credit_cnt !== CW'(CR)) begin n_err++; $display("FAIL edge_rst_credit got=%0d want=%0d", bus.credit_cnt, CR); end
      end
      step();
    end
  endtask

  task automatic test_random();
    int retp = 50;
    clear_ports();
    do_reset();
    rnd_body = 1;
    pgap = 25;
    for (int i = 0; i < NP; i++) pen[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        bus.timeout_limit = ($urandom_range(0, 3) == 0) ? TW'(0) : TW'($urandom_range(2, 8));
        case ($urandom_range(0, 2))
          0:       retp = 10;
          1:       retp = 50;
          default: retp = 90;
        endcase
      end
      for (int i = 0; i < NP; i++) begin
        if (ppos[i] >= ptot[i]) begin
          plen[i] = $urandom_range(2, 6);
          ptot[i] = plen[i] * $urandom_range(1, 3);
          ppos[i] = 0;
        end
      end
      bus.credit_ret = ($urandom_range(0, 99) < retp);
      rst = ($urandom_range(0, 299) == 0);
      apply_ports(); settle();
      n_cmp++;
      if (bus.grant !== exp_grant() || bus.xfer !== m_xfer || bus.credit_cnt !== CW'(m_cred) || bus.timeout_err !== m_terr) begin
        n_err++;
        $display("FAIL rand_cyc c=%0d grant=%b/%b xfer=%b/%b cred=%0d/%0d terr=%b/%b", c, bus.grant, exp_grant(), bus.xfer, m_xfer, bus.credit_cnt, m_cred, bus.timeout_err, m_terr);
      end
      step();
    end
    rst = 1'b0;
    bus.timeout_limit = '0;
  endtask

  initial begin
    bus.req = '0;
    bus.flit_id = '0;
    bus.credit_ret = 1'b0;
    bus.timeout_limit = '0;
    clear_ports();
    @(negedge clk);
    test_reset();
    test_single_packet();
    test_rr_order();
    test_credit_starve();
    test_timeout();
    test_credit_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001 Parameter NPORTS, default 5, number of requesters; bit order L=0, N=1, E=2, W=3, S=4.
REQ-002 Parameter CREDITS, default 4, downstream buffer depth in flits.
REQ-003 Parameter TOW, default 12, width of the timeout counter and limit.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NPORTS  per-port flit-available request.
REQ-007 flit_id  input  3*NPORTS  per-port flit type, port i at [3i+2:3i]: 001 header, 010 body, 100 tail, other = body.
REQ-008 credit_ret  input  1  downstream freed one buffer slot this cycle.
REQ-009 timeout_limit  input  TOW  maximum cycles a granted port may stall; 0 disables the timeout.
REQ-010 grant  output  NPORTS  one-hot or zero; owner of the output port.
REQ-011 xfer  output  1  a flit from the granted port moves this cycle.
REQ-012 credit_cnt  output  clog2(CREDITS+1)  available downstream credits.
REQ-013 timeout_err  output  1  one-cycle pulse when a packet is force-released.

Function
REQ-014 FSM states: IDLE, BUSY.
- grant is registered.
- xfer is combinational: xfer = BUSY & req[owner] & (credit_cnt != 0).
REQ-015 IDLE: if any req[i]=1 with flit_id[i]=001, grant the first such port searching round-robin from rr_ptr+1 (mod NPORTS).
- grant asserts next cycle; go to BUSY; rr_ptr <= granted index.
- Ports presenting non-header flits are ignored in IDLE.
REQ-016 BUSY: grant stays fixed until a tail flit transfers (xfer=1 with owner flit_id=100).
- Next cycle: grant=0, state=IDLE.
- No back-to-back grant without one IDLE cycle.
REQ-017 A header-and-tail single-flit packet does not exist; the 001 header is followed by at least one flit ending in 100.
REQ-018 Credits:
- credit_cnt decrements on xfer and increments on credit_ret.
- Both in the same cycle leaves it unchanged.
- Never exceeds CREDITS: a credit_ret at CREDITS is ignored.
- Never goes below 0: xfer is impossible at 0.
REQ-019 Stall counter:
- Cleared on entry to BUSY and on every xfer.
- Increments each BUSY cycle without xfer; saturates at all-ones.
REQ-020 When timeout_limit!=0 and stall counter == timeout_limit in BUSY:
- timeout_err pulses one cycle.
- grant clears next cycle; state=IDLE; rr_ptr still advances (owner loses priority).
REQ-021 A tail xfer and the timeout in the same cycle count as normal completion; timeout_err stays 0.
REQ-022 rr_ptr wraps from NPORTS-1 to 0.
REQ-023 Fairness: no port with a pending header waits more than NPORTS-1 packets.

Reset
REQ-024 On rst (synchronous, active-high):
- state=IDLE, grant=0, credit_cnt=CREDITS.
- stall counter=0, timeout_err=0, rr_ptr=NPORTS-1 (port 0 has first priority).
REQ-025 rst mid-packet abandons the packet immediately; credit_ret during rst is discarded.

Structure
REQ-026 Shared package noc_pkg holds:
- flit-id constants FLIT_HDR/FLIT_BODY/FLIT_TAIL;
- port index constants PORT_L..PORT_S;
- FSM state enum.
REQ-027 One sub-module rr_pick: combinational round-robin one-hot selector (request vector, pointer in, one-hot out), reusable by other allocators.

Verification
REQ-028 Reset, then L header + 3 body + tail with credit_ret tied 1:
- grant=00001 one cycle after header;
- 5 xfers;
- grant=0 the cycle after the tail.
REQ-029 All five ports present headers simultaneously, 2-flit packets each:
- grant order L,N,E,W,S;
- then repeat starting at L;
- one IDLE cycle between packets.
REQ-030 CREDITS=4, credit_ret=0, 6-flit packet on E:
- exactly 4 xfers, credit_cnt=0, xfer held low.
- Then one credit_ret pulse → one xfer.
REQ-031 timeout_limit=5, N granted, req[N] dropped after header:
- timeout_err pulses 5 stall cycles later;
- grant clears next cycle;
- pending S header granted afterwards.
REQ-032 Simultaneous xfer and credit_ret at credit_cnt=2 → stays 2.
- credit_ret at credit_cnt=CREDITS → stays CREDITS.
- rst asserted mid-packet → grant=0, credit_cnt=CREDITS next cycle.
